// File: rtl/gcl_gate_sequencer.sv
// GCL gate sequencer: preloads two GCL entries on test start, then walks the 16 slots of the
// current entry and drives the per-flow gate mask, double-buffering the next entry from RAM.
module gcl_gate_sequencer #(
    parameter int RAM_RD_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_test_start,
    input  logic [3:0]   in_slot_shift_cnt,
    input  logic [8:0]   in_slot_id,
    input  logic         in_gcl_ram_rd,
    output logic         out_gcl_rd_en,
    output logic [4:0]   out_gcl_rd_addr,
    input  logic [127:0] in_gcl_rd_data,
    output logic [7:0]   out_gate_state,
    output logic         out_gate_valid,
    output logic [8:0]   out_gate_slot_id,
    output logic         out_fetch_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE0 = 2'd1;
    localparam logic [1:0] ST_PRE1 = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    logic [1:0]            state;
    logic                  test_start_d;
    logic [3:0]            shift_q;
    logic [127:0]          cur_buf;
    logic [127:0]          next_buf;
    logic                  next_valid;
    logic [4:0]            entry_ptr;
    logic [RAM_RD_LAT-1:0] rd_pipe;
    logic [RAM_RD_LAT-1:0] rd_tag;

    logic       ts_rise;
    logic       ts_fall;
    logic       rd_ret;
    logic       ret_cur;
    logic       wrap;
    logic       busy;
    logic [4:0] next_addr;
    logic [7:0] cur_byte;

    always_comb begin
        ts_rise   = in_test_start & ~test_start_d;
        ts_fall   = ~in_test_start & test_start_d;
        rd_ret    = rd_pipe[RAM_RD_LAT-1];
        ret_cur   = rd_tag[RAM_RD_LAT-1];
        wrap      = (shift_q == 4'd15) && (in_slot_shift_cnt == 4'd0);
        // A read is outstanding from issue up to and including its return cycle.
        busy      = out_gcl_rd_en | (|rd_pipe);
        next_addr = entry_ptr + 5'd1;
        cur_byte  = cur_buf[{in_slot_shift_cnt, 3'b000} +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            test_start_d     <= 1'b0;
            shift_q          <= '0;
            cur_buf          <= '0;
            next_buf         <= '0;
            next_valid       <= 1'b0;
            entry_ptr        <= '0;
            rd_pipe          <= '0;
            rd_tag           <= '0;
            out_gcl_rd_en    <= 1'b0;
            out_gcl_rd_addr  <= '0;
            out_gate_state   <= '0;
            out_gate_valid   <= 1'b0;
            out_gate_slot_id <= '0;
            out_fetch_err    <= 1'b0;
        end else begin
            test_start_d  <= in_test_start;
            shift_q       <= in_slot_shift_cnt;
            out_gcl_rd_en <= 1'b0;
            rd_pipe       <= RAM_RD_LAT'({rd_pipe, out_gcl_rd_en});
            // Tag marks the addr-0 preload read, which fills cur_buf rather than next_buf.
            rd_tag        <= RAM_RD_LAT'({rd_tag, (state == ST_PRE0)});

            if (ts_fall) begin
                state            <= ST_IDLE;
                cur_buf          <= '0;
                next_buf         <= '0;
                next_valid       <= 1'b0;
                entry_ptr        <= '0;
                rd_pipe          <= '0;
                rd_tag           <= '0;
                out_gcl_rd_addr  <= '0;
                out_gate_state   <= '0;
                out_gate_valid   <= 1'b0;
                out_gate_slot_id <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ts_rise) begin
                            state           <= ST_PRE0;
                            out_gcl_rd_en   <= 1'b1;
                            out_gcl_rd_addr <= 5'd0;
                            out_fetch_err   <= 1'b0;
                        end
                    end
                    ST_PRE0: begin
                        state           <= ST_PRE1;
                        out_gcl_rd_en   <= 1'b1;
                        out_gcl_rd_addr <= 5'd1;
                    end
                    ST_PRE1: begin
                        if (rd_ret && ret_cur) begin
                            cur_buf <= in_gcl_rd_data;
                        end else if (rd_ret) begin
                            next_buf         <= in_gcl_rd_data;
                            next_valid       <= 1'b1;
                            entry_ptr        <= 5'd1;
                            state            <= ST_RUN;
                            out_gate_state   <= cur_byte;
                            out_gate_slot_id <= in_slot_id;
                            out_gate_valid   <= 1'b1;
                        end
                    end
                    default: begin
                        out_gate_slot_id <= in_slot_id;
                        out_gate_valid   <= 1'b1;
                        if (wrap) begin
                            cur_buf        <= next_valid ? next_buf : '0;
                            out_gate_state <= next_valid ? next_buf[7:0] : 8'h00;
                            next_valid     <= 1'b0;
                            if (!next_valid) begin
                                out_fetch_err <= 1'b1;
                            end
                        end else begin
                            out_gate_state <= cur_byte;
                        end
                        // A return coinciding with the wrap lands after the swap.
                        if (rd_ret) begin
                            next_buf   <= in_gcl_rd_data;
                            next_valid <= 1'b1;
                        end
                        if (in_gcl_ram_rd) begin
                            if (busy) begin
                                out_fetch_err <= 1'b1;
                            end else begin
                                entry_ptr       <= next_addr;
                                out_gcl_rd_en   <= 1'b1;
                                out_gcl_rd_addr <= next_addr;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gcl_gate_sequencer.sv
// Bench for gcl_gate_sequencer: RAM model with 2-cycle latency, an entry-index level model
// checked every cycle, and directed literal expectations for preload, walk, wrap, miss, stop, reset.
module tb_gcl_gate_sequencer;

    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         test_start = 1'b0;
    logic [3:0]   shift = '0;
    logic [8:0]   slot_id = '0;
    logic         gcl_rd = 1'b0;
    logic         rd_en;
    logic [4:0]   rd_addr;
    logic [127:0] rd_data;
    logic [7:0]   gate;
    logic         valid;
    logic [8:0]   gslot;
    logic         err;

    always #5 clk = ~clk;

    gcl_gate_sequencer #(.RAM_RD_LAT(LAT)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_test_start     (test_start),
        .in_slot_shift_cnt (shift),
        .in_slot_id        (slot_id),
        .in_gcl_ram_rd     (gcl_rd),
        .out_gcl_rd_en     (rd_en),
        .out_gcl_rd_addr   (rd_addr),
        .in_gcl_rd_data    (rd_data),
        .out_gate_state    (gate),
        .out_gate_valid    (valid),
        .out_gate_slot_id  (gslot),
        .out_fetch_err     (err)
    );

    // GCL RAM: data valid LAT cycles after rd_en, garbage otherwise
    logic [127:0] ram [32];
    logic         rv0 = 1'b0, rv1 = 1'b0;
    logic [4:0]   ra0 = '0, ra1 = '0;
    always @(posedge clk) begin
        rv0 <= rd_en;
        ra0 <= rd_addr;
        rv1 <= rv0;
        ra1 <= ra0;
    end
    assign rd_data = rv1 ? ram[ra1] : {4{32'hDEADBEEF}};

    int n_chk = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;
    int sid = 0;

    function automatic void chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endfunction

    function automatic logic [7:0] ent_byte(int idx, int s);
        logic [127:0] w;
        if (idx < 0) return 8'h00;
        w = ram[idx];
        return w[8*s +: 8];
    endfunction

    // Model: tracks which RAM entry is current/next by index, reads as timestamped returns
    int         mode, cyc, rise, cur, nxt, ptr, pend_cyc, pend_addr, sh_p;
    bit         nok, pend, busy_now, ts_p;
    logic [7:0] e_gate;
    logic       e_valid, e_err, e_rd;
    logic [8:0] e_slot;
    logic [4:0] e_addr;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mode = 0; cyc = 0; rise = 0; cur = -1; nxt = -1; ptr = 0; pend = 0; nok = 0;
                ts_p = 0; sh_p = 0; e_gate = 0; e_valid = 0; e_slot = 0; e_err = 0; e_rd = 0; e_addr = 0;
            end else begin
                cyc++;
                e_rd = 0;
                if (ts_p && !test_start) begin
                    mode = 0; cur = -1; nxt = -1; nok = 0; ptr = 0; pend = 0;
                    e_gate = 0; e_valid = 0; e_slot = 0; e_addr = 0;
                end else if (mode == 0) begin
                    if (test_start && !ts_p) begin
                        mode = 1; rise = cyc; e_err = 0; e_rd = 1; e_addr = 0;
                    end
                end else if (mode == 1) begin
                    if (cyc == rise + 1) begin
                        e_rd = 1; e_addr = 1;
                    end
                    if (cyc == rise + 2 + LAT) begin
                        mode = 2; cur = 0; nxt = 1; nok = 1; ptr = 1;
                        e_gate = ent_byte(0, int'(shift)); e_slot = slot_id; e_valid = 1;
                    end
                end else begin
                    busy_now = pend;
                    if (sh_p == 15 && shift == 0) begin
                        if (nok) cur = nxt;
                        else begin
                            cur = -1; e_err = 1;
                        end
                        nok = 0;
                    end
                    e_gate = ent_byte(cur, int'(shift)); e_slot = slot_id; e_valid = 1;
                    if (pend && cyc == pend_cyc) begin
                        nxt = pend_addr; nok = 1; pend = 0;
                    end
                    if (gcl_rd) begin
                        if (busy_now) e_err = 1;
                        else begin
                            ptr = (ptr + 1) % 32;
                            e_rd = 1; e_addr = 5'(ptr);
                            pend = 1; pend_cyc = cyc + LAT + 1; pend_addr = ptr;
                        end
                    end
                end
                ts_p = test_start;
                sh_p = int'(shift);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("m_gate", int'(gate), int'(e_gate));
                chk("m_valid", int'(valid), int'(e_valid));
                chk("m_slot", int'(gslot), int'(e_slot));
                chk("m_err", int'(err), int'(e_err));
                chk("m_rd_en", int'(rd_en), int'(e_rd));
                if (e_rd) chk("m_rd_addr", int'(rd_addr), int'(e_addr));
            end
        end
    end

    task automatic tick(input int sh, input bit rd);
        @(posedge clk);
        #1;
        shift  = 4'(sh);
        gcl_rd = rd;
    endtask

    // idx: RAM entry expected to drive the gates for this entry (-1 = closed)
    task automatic run_entry(input bit fetch, input int exp_addr, input int idx);
        for (int s = 0; s < 16; s++) begin
            for (int c = 0; c < 4; c++) begin
                tick(s, fetch && s == 15 && c == 1);
                if (c == 0) begin
                    sid = (sid + 1) % 512;
                    slot_id = 9'(sid);
                end
                if (c == 1) chk("entry_gate", int'(gate), int'(ent_byte(idx, s)));
                if (c == 2 && s == 15 && fetch) begin
                    chk("pf_rd_en", int'(rd_en), 1);
                    chk("pf_rd_addr", int'(rd_addr), exp_addr);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 32; i++)
            for (int s = 0; s < 16; s++)
                ram[i][8*s +: 8] = 8'(i * 37 + s * 11 + 3);
        ram[0][7:0] = 8'hA5;

        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_on = 1'b1;
        repeat (3) tick(0, 0);
        chk("idle_rd_en", int'(rd_en), 0);
        chk("idle_valid", int'(valid), 0);

        // preload: valid with RAM[0][7:0] on the 5th edge after the rise is sampled
        test_start = 1'b1;
        n = 0;
        while (n < 20 && !valid) begin
            tick(0, 0);
            n++;
        end
        chk("preload_cycles", n, 5);
        chk("preload_gate", int'(gate), 8'hA5);

        // back-to-back requests: second one while outstanding
        tick(0, 0);
        tick(0, 1);
        tick(0, 1);
        tick(0, 0);
        chk("dbl_req_err", int'(err), 1);
        test_start = 1'b0;
        tick(0, 0);
        chk("stop_valid", int'(valid), 0);
        chk("stop_err_sticky", int'(err), 1);
        repeat (6) tick(0, 0);

        for (int s = 0; s < 16; s++) ram[0][8*s +: 8] = 8'(s);
        test_start = 1'b1;
        tick(0, 0);
        chk("restart_rd_en", int'(rd_en), 1);
        chk("restart_rd_addr", int'(rd_addr), 0);
        chk("restart_err_clr", int'(err), 0);
        repeat (4) tick(0, 0);
        chk("restart_valid", int'(valid), 1);

        // slot walk and full period
        run_entry(1, 2, 0);
        for (int k = 1; k < 32; k++) run_entry(1, (k + 2) % 32, k);
        run_entry(1, 2, 0);
        chk("period_err", int'(err), 0);

        // missed fetch: closed entry two wraps later
        run_entry(0, -1, 1);
        run_entry(1, 3, 2);
        run_entry(1, 4, -1);
        chk("miss_err", int'(err), 1);
        run_entry(0, -1, 3);

        // stop mid-entry with a read in flight
        tick(0, 0);
        tick(0, 0);
        chk("mid_gate", int'(gate), int'(ent_byte(4, 0)));
        tick(1, 0);
        tick(1, 1);
        tick(1, 0);
        test_start = 1'b0;
        tick(1, 0);
        chk("stop2_valid", int'(valid), 0);
        repeat (6) tick(1, 0);
        tick(0, 0);
        test_start = 1'b1;
        tick(0, 0);
        chk("restart2_rd_en", int'(rd_en), 1);
        chk("restart2_rd_addr", int'(rd_addr), 0);
        chk("restart2_err_clr", int'(err), 0);
        repeat (4) tick(0, 0);
        run_entry(1, 2, 0);

        // asynchronous reset mid-run
        tick(0, 0);
        tick(1, 0);
        rst_n = 1'b0;
        test_start = 1'b0;
        #1;
        chk("rst_gate", int'(gate), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_slot", int'(gslot), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        tick(0, 0);
        tick(0, 0);
        rst_n = 1'b1;
        repeat (4) tick(0, 0);
        chk("post_rst_rd_en", int'(rd_en), 0);
        chk("post_rst_valid", int'(valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
